// File: rtl/load_return_unit_pkg.sv
// Shared memop encodings and the per-load bookkeeping record used by the
// load return path.
package load_return_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_D  = 3'd3,
    MEM_UB = 3'd4,
    MEM_UH = 3'd5,
    MEM_UW = 3'd6
  } memop_e;

  // Widest destination index a record can carry; narrower RD_W uses the low bits.
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic [2:0]          shift;
    memop_e              memop;
    logic [RD_W_MAX-1:0] rd;
  } load_req_t;

endpackage

// File: rtl/load_return_unit_extend.sv
// Lane extraction and sign/zero extension of a raw doubleword read.
module load_extend
  import load_return_unit_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_shift,
  input  memop_e      i_memop,
  output logic [63:0] o_result
);

  logic [63:0]        w_lane;
  logic signed [7:0]  w_b_s;
  logic signed [15:0] w_h_s;
  logic signed [31:0] w_w_s;

  // Bytes shifted past bit 63 fall off and read back as zero.
  assign w_lane = i_rdata >> {i_shift, 3'b000};
  assign w_b_s  = w_lane[7:0];
  assign w_h_s  = w_lane[15:0];
  assign w_w_s  = w_lane[31:0];

  always_comb begin
    o_result = '0;
    case (i_memop)
      MEM_B:   o_result = 64'(w_b_s);
      MEM_H:   o_result = 64'(w_h_s);
      MEM_W:   o_result = 64'(w_w_s);
      MEM_D:   o_result = w_lane;
      MEM_UB:  o_result = {56'd0, w_lane[7:0]};
      MEM_UH:  o_result = {48'd0, w_lane[15:0]};
      MEM_UW:  o_result = {32'd0, w_lane[31:0]};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/load_return_unit.sv
// Pairs in-order memory read responses with recorded loads, aligns the data
// and buffers one writeback result; flushed loads are dropped on return.
module load_return_unit
  import load_return_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_shift,
  input  logic [2:0]      req_memop,
  input  logic [RD_W-1:0] req_rd,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic [63:0]     mem_rdata,
  input  logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [63:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            busy,
  output logic            err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  load_req_t        r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_drop;
  logic             r_wb_valid;
  logic [63:0]      r_wb_data;
  logic [RD_W-1:0]  r_wb_rd;
  logic             r_err;

  load_req_t        w_req;
  load_req_t        w_head;
  logic [CNT_W:0]   w_occ;
  logic             w_push;
  logic             w_fire;
  logic             w_fire_drop;
  logic             w_pop;
  logic             w_fire_stray;
  logic [63:0]      w_ext;

  always_comb begin
    w_req          = '0;
    w_req.shift    = req_shift;
    w_req.memop    = memop_e'(req_memop);
    w_req.rd[RD_W-1:0] = req_rd;
  end

  // Flushed-but-outstanding loads still occupy memory-side slots.
  assign w_occ        = {1'b0, r_count} + {1'b0, r_drop};
  assign req_ready    = !flush && (w_occ < (CNT_W+1)'(DEPTH));
  assign mem_rready   = !r_wb_valid || wb_ready;
  assign w_push       = req_valid && req_ready;
  assign w_fire       = mem_rvalid && mem_rready;
  assign w_fire_drop  = w_fire && (r_drop != '0);
  assign w_pop        = w_fire && (r_drop == '0) && (r_count != '0);
  assign w_fire_stray = w_fire && (r_drop == '0) && (r_count == '0);
  assign w_head       = r_fifo[r_rd_ptr];

  load_extend u_extend (
    .i_rdata  (mem_rdata),
    .i_shift  (w_head.shift),
    .i_memop  (w_head.memop),
    .o_result (w_ext)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_fire_stray) r_err <= 1'b1;
      if (flush) begin
        // Every still-queued load becomes a pending drop, net of this cycle's response.
        r_rd_ptr   <= r_wr_ptr;
        r_count    <= '0;
        r_drop     <= r_drop + r_count - CNT_W'(w_pop) - CNT_W'(w_fire_drop);
        r_wb_valid <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        r_drop  <= r_drop - CNT_W'(w_fire_drop);
        if (w_pop) begin
          r_wb_valid <= 1'b1;
          r_wb_data  <= w_ext;
          r_wb_rd    <= w_head.rd[RD_W-1:0];
        end else if (wb_ready) begin
          r_wb_valid <= 1'b0;
        end
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign wb_rd    = r_wb_rd;
  assign err      = r_err;
  assign busy     = (r_count != '0) || (r_drop != '0) || r_wb_valid;

endmodule

// File: tb/tb_load_return_unit.sv
// Scoreboard bench for load_return_unit: directed loads, ordering,
// backpressure, flush, stray responses and asynchronous reset.
module tb_load_return_unit;
  import load_return_unit_pkg::*;

  localparam int RD_W = 5;
  localparam logic [63:0] D = 64'h1122_3344_8566_7788;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_shift = '0;
  logic [2:0]      req_memop = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            mem_rvalid = 1'b0;
  logic            mem_rready;
  logic [63:0]     mem_rdata = '0;
  logic            flush = 1'b0;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [63:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            busy;
  logic            err;

  load_return_unit #(.DEPTH(2), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_shift(req_shift),
    .req_memop(req_memop), .req_rd(req_rd),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [RD_W+63:0] sb [$];
  logic [RD_W+63:0] mon_e;
  logic [63:0]      hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no result", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(mon_e[RD_W+63:64]));
        chk("wb_data", wb_data, mon_e[63:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] sh, input memop_e op, input logic [RD_W-1:0] rd);
    req_valid = 1'b1;
    req_shift = sh;
    req_memop = op;
    req_rd    = rd;
    #1;
    chk("req_ready_issue", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic exp_out, input logic [RD_W-1:0] rd, input logic [63:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = D;
    if (exp_out) sb.push_back({rd, data});
    tick();
    mem_rvalid = 1'b0;
    chk(exp_out ? "wb_valid_latency" : "wb_valid_none", 64'(wb_valid), 64'(exp_out));
  endtask

  memop_e      s_op   [6] = '{MEM_B, MEM_UB, MEM_H, MEM_W, MEM_UW, MEM_D};
  logic [2:0]  s_sh   [6] = '{3'd3, 3'd3, 3'd2, 3'd4, 3'd0, 3'd0};
  logic [63:0] s_exp  [6] = '{64'hFFFF_FFFF_FFFF_FF85, 64'h85, 64'hFFFF_FFFF_FFFF_8566,
                              64'h1122_3344, 64'h8566_7788, 64'h1122_3344_8566_7788};

  initial begin
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_rready", 64'(mem_rready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;

    // single loads
    for (int i = 0; i < 6; i++) begin
      issue(s_sh[i], s_op[i], RD_W'(i + 1));
      chk("wb_idle_before", 64'(wb_valid), 64'd0);
      respond(1'b1, RD_W'(i + 1), s_exp[i]);
      tick();
    end

    // ordering, queue full at DEPTH
    issue(3'd0, MEM_UB, 5'd3);
    issue(3'd6, MEM_UH, 5'd7);
    #1;
    chk("req_ready_full", 64'(req_ready), 64'd0);
    respond(1'b1, 5'd3, 64'h88);
    respond(1'b1, 5'd7, 64'h1122);
    tick();

    // backpressure
    wb_ready = 1'b0;
    issue(3'd0, MEM_D, 5'd1);
    issue(3'd3, MEM_UB, 5'd2);
    respond(1'b1, 5'd1, D);
    mem_rvalid = 1'b1;
    mem_rdata  = D;
    #1;
    chk("bp_mem_rready", 64'(mem_rready), 64'd0);
    hold = wb_data;
    repeat (3) tick();
    chk("bp_data_stable", wb_data, hold);
    chk("bp_rd_stable", 64'(wb_rd), 64'd1);
    chk("bp_valid_held", 64'(wb_valid), 64'd1);
    sb.push_back({5'd2, 64'h85});
    wb_ready = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("bp_second_valid", 64'(wb_valid), 64'd1);
    chk("bp_second_rd", 64'(wb_rd), 64'd2);
    tick();

    // flush with two queued
    issue(3'd1, MEM_B, 5'd4);
    issue(3'd2, MEM_H, 5'd5);
    chk("fl_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    chk("fl_req_ready_during", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_wb_valid", 64'(wb_valid), 64'd0);
    chk("fl_drop_blocks_req", 64'(req_ready), 64'd0);
    chk("fl_busy_after", 64'(busy), 64'd1);
    respond(1'b0, 5'd0, 64'd0);
    #1;
    chk("fl_req_ready_after_drop", 64'(req_ready), 64'd1);
    issue(3'd2, MEM_H, 5'd9);
    respond(1'b0, 5'd0, 64'd0);
    respond(1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_8566);
    chk("fl_no_err", 64'(err), 64'd0);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // stray response
    respond(1'b0, 5'd0, 64'd0);
    chk("stray_err", 64'(err), 64'd1);
    tick();
    tick();
    chk("stray_err_sticky", 64'(err), 64'd1);

    // asynchronous reset mid-burst
    wb_ready = 1'b0;
    issue(3'd0, MEM_D, 5'd11);
    issue(3'd0, MEM_D, 5'd12);
    respond(1'b1, 5'd11, D);
    chk("ar_busy_before", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wb_valid", 64'(wb_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd1);
    chk("ar_mem_rready", 64'(mem_rready), 64'd1);
    chk("ar_err", 64'(err), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
